combat_referee: RTL and testbench
=================================

// Module: combat_referee
// PURPOSE
// Central hit/damage controller for the two character animation FSMs. Samples each
// character's attack/defense status and screen X position once per frame tick,
// decides whether a hit lands, and debits HP. Drives the hurt/die requests back into
// both character FSMs and reports round end to the game-state logic.
// PARAMETERS
// HP_MAX          8'd100  starting and restart HP per character
// DAMAGE          8'd10   HP lost on an unblocked hit
// DAMAGE_BLOCKED  8'd2    HP lost when the victim's defense is high on the tick
// HIT_RANGE       10'd80  max |pos_x1-pos_x2| for a hit to land (inclusive)
// HURT_HOLD       8'd4    frame ticks a hurt request stays asserted
// PORTS
// Clk         in   1   system clock
// Reset       in   1   asynchronous, active-low reset
// frame_clk   in   1   vertical-sync frame clock, asynchronous to Clk logic
// game_state  in   8   0=start, 1=game, 2=gameover
// attack1/2   in   1   character 1/2 FSM is in its attack state
// defense1/2  in   1   character 1/2 FSM is in its defense state
// pos_x1/2    in   10  character 1/2 screen X position, unsigned
// hurt1/2     out  1   hurt request to character 1/2 FSM
// die1/2      out  1   die request to character 1/2 FSM, sticky
// hp1/2       out  8   current HP, unsigned
// round_over  out  1   high while phase is KO
// winner      out  2   0=none, 1=char1, 2=char2, 3=double KO
// BEHAVIOUR
// - Reset low: hp1/hp2=HP_MAX; hurt*, die*, round_over=0; winner=0; phase WAIT; hit engines IDLE.
// - Tick: frame_clk registered once, edge registered again; tick is one Clk wide, 2 Clk after the
//   frame_clk rise. All evaluation happens on tick Clks; outputs update on the next Clk edge.
// - Restart: rising edge of (game_state==1) detected each Clk (not gated by tick). Restart reloads
//   the HPs, clears hurt/die/winner/round_over and the hurt counters, sets hit engines IDLE and
//   phase FIGHT. Restart wins over a same-Clk tick.
// - Phase FSM: WAIT -(restart)-> FIGHT -(hp1==0 or hp2==0 after debit)-> KO -(restart)-> FIGHT.
//   Hits are evaluated only in FIGHT. In KO all hit engines are frozen, and hp is frozen.
// - Per-attacker hit engine, one per character. It is evaluated only on ticks:
//   IDLE  : attackN=1 -> ARMED
//   ARMED : attackN=0 -> IDLE; in range and victim not die -> land hit, -> SPENT
//   SPENT : attackN=0 -> IDLE. Result: at most one hit per continuous attack assertion.
// - Range: the distance is computed as an 11-bit absolute difference, with no wrap.
//   An ARMED engine lands on the same tick it enters range.
// - Debit: dmg = victim defense ? DAMAGE_BLOCKED : DAMAGE. The result saturates at 0 and never underflows.
// - Both engines landing on the same tick: both debits apply on that tick.
// - hurtN: on a landed hit, and only if the victim's new hp>0, set hurtN=1 and load the counter with
//   HURT_HOLD. The counter decrements on each tick and hurtN drops when it reaches 0.
//   A new hit while hurtN is high reloads the counter.
// - dieN: set on the tick where hpN reaches 0, and cleared only by reset or restart. hurtN is forced to 0
//   while dieN=1.
// - Winner on entry to KO: only hp2==0 -> 1; only hp1==0 -> 2; both zero -> 3.
//   round_over=1 from that Clk.
// - game_state leaving 1 mid-FIGHT has no effect; only a new restart edge re-arms.
// TESTING
// T1 reset: Reset=0 -> hp1=hp2=100, hurt*/die*=0, winner=0, round_over=0. Set game_state 0->1 -> phase FIGHT.
// T2 hit: attack1=1, |dx|=50, no defense for 1 tick -> hp2=90, hurt2=1 for exactly 4 ticks.
//    Holding attack1 for 20 more ticks -> hp2 stays 90.
// T3 block/range: defense2=1 on hit -> hp2 drops by 2. With dx=81 there is no hit; moving to dx=80 while
//    the attack is held -> hit on that tick.
// T4 KO: ten unblocked hits on char2 -> hp2=0, die2=1, hurt2=0, round_over=1, winner=1.
//    Further attacks -> no change.
// T5 double KO: hp1=hp2=10, both attacks land on the same tick -> hp1=hp2=0, winner=3.
// T6 restart/async: restart edge in KO -> hp=100, flags clear. Reset low mid-hurt asynchronously
//    clears outputs without waiting for a Clk.

Source files
------------

// File: rtl/combat_referee.sv
`default_nettype none
// ============================================================================
// Module   : combat_referee
// Purpose  : Hit/damage referee for two fighting characters. Samples attack,
//            defense and X position once per frame tick, lands at most one
//            hit per continuous attack, debits HP with saturation at zero,
//            drives hurt/die requests and reports the round winner.
// Ports    : Clk, Reset (async, active-low), frame_clk (async vsync),
//            game_state[7:0] (1 = game), attack1/2, defense1/2,
//            pos_x1/2[9:0] -> hurt1/2, die1/2, hp1/2[7:0], round_over,
//            winner[1:0] (0 none, 1 char1, 2 char2, 3 double KO)
// Revision : 1.0 - initial release
// ============================================================================
module combat_referee #(
  parameter logic [7:0] HP_MAX         = 8'd100,
  parameter logic [7:0] DAMAGE         = 8'd10,
  parameter logic [7:0] DAMAGE_BLOCKED = 8'd2,
  parameter logic [9:0] HIT_RANGE      = 10'd80,
  parameter logic [7:0] HURT_HOLD      = 8'd4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] game_state,
  input  logic       attack1,
  input  logic       attack2,
  input  logic       defense1,
  input  logic       defense2,
  input  logic [9:0] pos_x1,
  input  logic [9:0] pos_x2,
  output logic       hurt1,
  output logic       hurt2,
  output logic       die1,
  output logic       die2,
  output logic [7:0] hp1,
  output logic [7:0] hp2,
  output logic       round_over,
  output logic [1:0] winner
);

  localparam logic [1:0] PH_WAIT  = 2'd0;
  localparam logic [1:0] PH_FIGHT = 2'd1;
  localparam logic [1:0] PH_KO    = 2'd2;

  localparam logic [1:0] EN_IDLE  = 2'd0;
  localparam logic [1:0] EN_ARMED = 2'd1;
  localparam logic [1:0] EN_SPENT = 2'd2;

  logic       fc1_q, fc1_d, fc2_q, fc2_d, tick_q, tick_d;
  logic       gs_q, gs_d;
  logic [1:0] phase_q, phase_d;
  logic [1:0] eng1_q, eng1_d, eng2_q, eng2_d;
  logic [7:0] hp1_q, hp1_d, hp2_q, hp2_d;
  logic [7:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic       hurt1_q, hurt1_d, hurt2_q, hurt2_d;
  logic       die1_q, die1_d, die2_q, die2_d;
  logic       round_over_q, round_over_d;
  logic [1:0] winner_q, winner_d;

  logic        gs_active, restart;
  logic [10:0] x1_ext, x2_ext, dx;
  logic        in_range;
  logic [2:0]  eng1_step, eng2_step;
  logic        land1, land2;

  // Returns {land, next_state}. One hit per continuous attack: after landing
  // the engine sits in SPENT until the attack input drops.
  function automatic logic [2:0] engine_step(input logic [1:0] st,
                                             input logic       atk,
                                             input logic       can_hit);
    logic [1:0] nxt;
    logic       land;
    nxt  = st;
    land = 1'b0;
    case (st)
      EN_IDLE:  if (atk) nxt = EN_ARMED;
      EN_ARMED: begin
        if (!atk) begin
          nxt = EN_IDLE;
        end else if (can_hit) begin
          land = 1'b1;
          nxt  = EN_SPENT;
        end
      end
      EN_SPENT: if (!atk) nxt = EN_IDLE;
      default:  nxt = EN_IDLE;
    endcase
    return {land, nxt};
  endfunction

  // Saturating HP debit; a blocked hit costs less.
  function automatic logic [7:0] debit(input logic [7:0] hp, input logic blocked);
    logic [7:0] dmg;
    dmg = blocked ? DAMAGE_BLOCKED : DAMAGE;
    return (hp > dmg) ? (hp - dmg) : 8'd0;
  endfunction

  assign gs_active = (game_state == 8'd1);
  assign restart   = gs_active & ~gs_q;

  // 11-bit absolute distance so the subtraction never wraps.
  assign x1_ext   = {1'b0, pos_x1};
  assign x2_ext   = {1'b0, pos_x2};
  assign dx       = (x1_ext >= x2_ext) ? (x1_ext - x2_ext) : (x2_ext - x1_ext);
  assign in_range = (dx <= {1'b0, HIT_RANGE});

  // Engine 1 attacks character 2 and vice versa.
  assign eng1_step = engine_step(eng1_q, attack1, in_range & ~die2_q);
  assign eng2_step = engine_step(eng2_q, attack2, in_range & ~die1_q);
  assign land1     = eng1_step[2];
  assign land2     = eng2_step[2];

  always_comb begin
    fc1_d        = frame_clk;
    fc2_d        = fc1_q;
    tick_d       = fc1_q & ~fc2_q;
    gs_d         = gs_active;
    phase_d      = phase_q;
    eng1_d       = eng1_q;
    eng2_d       = eng2_q;
    hp1_d        = hp1_q;
    hp2_d        = hp2_q;
    cnt1_d       = cnt1_q;
    cnt2_d       = cnt2_q;
    die1_d       = die1_q;
    die2_d       = die2_q;
    round_over_d = round_over_q;
    winner_d     = winner_q;

    if (restart) begin
      // Restart takes priority over a coincident tick.
      phase_d      = PH_FIGHT;
      eng1_d       = EN_IDLE;
      eng2_d       = EN_IDLE;
      hp1_d        = HP_MAX;
      hp2_d        = HP_MAX;
      cnt1_d       = 8'd0;
      cnt2_d       = 8'd0;
      die1_d       = 1'b0;
      die2_d       = 1'b0;
      round_over_d = 1'b0;
      winner_d     = 2'd0;
    end else if (tick_q) begin
      if (cnt1_q != 8'd0) cnt1_d = cnt1_q - 8'd1;
      if (cnt2_q != 8'd0) cnt2_d = cnt2_q - 8'd1;

      if (phase_q == PH_FIGHT) begin
        eng1_d = eng1_step[1:0];
        eng2_d = eng2_step[1:0];

        if (land1) begin
          hp2_d = debit(hp2_q, defense2);
          if (hp2_d == 8'd0) begin
            die2_d = 1'b1;
            cnt2_d = 8'd0;
          end else begin
            cnt2_d = HURT_HOLD;
          end
        end

        if (land2) begin
          hp1_d = debit(hp1_q, defense1);
          if (hp1_d == 8'd0) begin
            die1_d = 1'b1;
            cnt1_d = 8'd0;
          end else begin
            cnt1_d = HURT_HOLD;
          end
        end

        // Winner encoding falls out of {hp1 dead, hp2 dead}.
        if ((hp1_d == 8'd0) || (hp2_d == 8'd0)) begin
          phase_d      = PH_KO;
          round_over_d = 1'b1;
          winner_d     = {(hp1_d == 8'd0), (hp2_d == 8'd0)};
        end
      end
    end

    hurt1_d = (cnt1_d != 8'd0) && !die1_d;
    hurt2_d = (cnt2_d != 8'd0) && !die2_d;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fc1_q        <= 1'b0;
      fc2_q        <= 1'b0;
      tick_q       <= 1'b0;
      gs_q         <= 1'b0;
      phase_q      <= PH_WAIT;
      eng1_q       <= EN_IDLE;
      eng2_q       <= EN_IDLE;
      hp1_q        <= HP_MAX;
      hp2_q        <= HP_MAX;
      cnt1_q       <= 8'd0;
      cnt2_q       <= 8'd0;
      hurt1_q      <= 1'b0;
      hurt2_q      <= 1'b0;
      die1_q       <= 1'b0;
      die2_q       <= 1'b0;
      round_over_q <= 1'b0;
      winner_q     <= 2'd0;
    end else begin
      fc1_q        <= fc1_d;
      fc2_q        <= fc2_d;
      tick_q       <= tick_d;
      gs_q         <= gs_d;
      phase_q      <= phase_d;
      eng1_q       <= eng1_d;
      eng2_q       <= eng2_d;
      hp1_q        <= hp1_d;
      hp2_q        <= hp2_d;
      cnt1_q       <= cnt1_d;
      cnt2_q       <= cnt2_d;
      hurt1_q      <= hurt1_d;
      hurt2_q      <= hurt2_d;
      die1_q       <= die1_d;
      die2_q       <= die2_d;
      round_over_q <= round_over_d;
      winner_q     <= winner_d;
    end
  end

  assign hurt1      = hurt1_q;
  assign hurt2      = hurt2_q;
  assign die1       = die1_q;
  assign die2       = die2_q;
  assign hp1        = hp1_q;
  assign hp2        = hp2_q;
  assign round_over = round_over_q;
  assign winner     = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_combat_referee.sv
`default_nettype none
// ============================================================================
// Module   : tb_combat_referee
// Purpose  : Directed, table-driven bench for combat_referee with
//            hand-computed expectations plus multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_combat_referee;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] game_state = 8'd0;
  logic       attack1 = 1'b0, attack2 = 1'b0, defense1 = 1'b0, defense2 = 1'b0;
  logic [9:0] pos_x1 = 10'd100, pos_x2 = 10'd150;
  logic       hurt1, hurt2, die1, die2, round_over;
  logic [7:0] hp1, hp2;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;

  combat_referee dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .game_state (game_state),
    .attack1    (attack1),
    .attack2    (attack2),
    .defense1   (defense1),
    .defense2   (defense2),
    .pos_x1     (pos_x1),
    .pos_x2     (pos_x2),
    .hurt1      (hurt1),
    .hurt2      (hurt2),
    .die1       (die1),
    .die2       (die2),
    .hp1        (hp1),
    .hp2        (hp2),
    .round_over (round_over),
    .winner     (winner)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       a1, a2, d1, d2;
    logic [9:0] x1, x2;
    logic [7:0] hp1, hp2;
    logic       h1, h2;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame: frame_clk high for 3 Clks then low for 3; the evaluating
  // edge is the third posedge after the rise. Returns on a negedge.
  task automatic frame();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic do_restart();
    game_state = 8'd0;
    repeat (2) @(negedge Clk);
    game_state = 8'd1;
    repeat (2) @(negedge Clk);
  endtask

  // Arm, land, release: one hit from character 1 on character 2.
  task automatic hit1();
    attack1 = 1'b1;
    frame();
    frame();
    attack1 = 1'b0;
    frame();
  endtask

  task automatic hit_both();
    attack1 = 1'b1;
    attack2 = 1'b1;
    frame();
    frame();
    attack1 = 1'b0;
    attack2 = 1'b0;
    frame();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " hp1"}, hp1, 100);
    check({tag, " hp2"}, hp2, 100);
    check({tag, " flags"}, {hurt1, hurt2, die1, die2, round_over, winner}, 0);
  endtask

  initial begin
    //        a1 a2 d1 d2  x1    x2    hp1  hp2  h1 h2
    vecs[0]  = '{1, 0, 0, 0, 100, 150, 100, 100, 0, 0};  // arm
    vecs[1]  = '{1, 0, 0, 0, 100, 150, 100,  90, 0, 1};  // hit, hold 4
    vecs[2]  = '{1, 0, 0, 0, 100, 150, 100,  90, 0, 1};
    vecs[3]  = '{1, 0, 0, 0, 100, 150, 100,  90, 0, 1};
    vecs[4]  = '{1, 0, 0, 0, 100, 150, 100,  90, 0, 1};
    vecs[5]  = '{1, 0, 0, 0, 100, 150, 100,  90, 0, 0};  // hurt expires
    vecs[6]  = '{0, 0, 0, 0, 100, 150, 100,  90, 0, 0};  // release
    vecs[7]  = '{1, 0, 0, 1, 100, 150, 100,  90, 0, 0};  // arm
    vecs[8]  = '{1, 0, 0, 1, 100, 150, 100,  88, 0, 1};  // blocked hit
    vecs[9]  = '{0, 0, 0, 0, 100, 181, 100,  88, 0, 1};
    vecs[10] = '{1, 0, 0, 0, 100, 181, 100,  88, 0, 1};  // arm, dx=81
    vecs[11] = '{1, 0, 0, 0, 100, 181, 100,  88, 0, 1};  // out of range
    vecs[12] = '{1, 0, 0, 0, 100, 180, 100,  78, 0, 1};  // dx=80 lands
    vecs[13] = '{0, 1, 0, 0, 100, 180, 100,  78, 0, 1};  // engine 2 arms
    vecs[14] = '{0, 1, 0, 0, 100, 180,  90,  78, 1, 1};  // char2 hits char1
    vecs[15] = '{0, 0, 0, 0, 100, 180,  90,  78, 1, 1};
    vecs[16] = '{0, 0, 0, 0, 100, 180,  90,  78, 1, 0};
    vecs[17] = '{1, 0, 0, 0, 900,   0,  90,  78, 1, 0};  // far: arm
    vecs[18] = '{1, 0, 0, 0, 900,   0,  90,  78, 0, 0};  // no wrap, no hit
    vecs[19] = '{0, 0, 0, 0, 300, 250,  90,  78, 0, 0};
    vecs[20] = '{0, 1, 1, 0, 300, 250,  90,  78, 0, 0};  // arm, x1>x2
    vecs[21] = '{0, 1, 1, 0, 300, 250,  88,  78, 1, 0};  // blocked on char1
    vecs[22] = '{0, 0, 0, 0, 100, 150,  88,  78, 1, 0};

    // Asynchronous reset at time 2, before any Clk edge.
    #2 Reset = 1'b0;
    #1;
    check_cleared("reset");
    repeat (3) @(negedge Clk);
    Reset = 1'b1;

    // WAIT phase: attacks have no effect before a restart edge.
    attack1 = 1'b1;
    frame();
    frame();
    frame();
    attack1 = 1'b0;
    frame();
    check("wait no hit hp2", hp2, 100);

    do_restart();
    check_cleared("restart1");

    for (int i = 0; i < 23; i++) begin
      attack1  = vecs[i].a1;
      attack2  = vecs[i].a2;
      defense1 = vecs[i].d1;
      defense2 = vecs[i].d2;
      pos_x1   = vecs[i].x1;
      pos_x2   = vecs[i].x2;
      frame();
      check($sformatf("v%0d hp1", i), hp1, vecs[i].hp1);
      check($sformatf("v%0d hp2", i), hp2, vecs[i].hp2);
      check($sformatf("v%0d hurt1", i), hurt1, vecs[i].h1);
      check($sformatf("v%0d hurt2", i), hurt2, vecs[i].h2);
      check($sformatf("v%0d ko flags", i), {die1, die2, round_over, winner}, 0);
    end

    // game_state leaving 1 mid-fight is ignored; long hold gives one hit.
    game_state = 8'd0;
    attack1 = 1'b1;
    frame();
    frame();
    check("hold first hit hp2", hp2, 68);
    repeat (20) frame();
    check("hold 20 hp2", hp2, 68);
    check("hold 20 hurt2", hurt2, 0);
    attack1 = 1'b0;
    frame();

    // KO with saturation: 9 hits -> 10, blocked -> 8, then 8-10 clamps to 0.
    do_restart();
    check_cleared("restart2");
    repeat (9) hit1();
    check("ko pre hp2", hp2, 10);
    check("ko pre die2", die2, 0);
    defense2 = 1'b1;
    hit1();
    defense2 = 1'b0;
    check("ko blocked hp2", hp2, 8);
    check("ko blocked hurt2", hurt2, 1);
    hit1();
    check("ko hp2", hp2, 0);
    check("ko die2", die2, 1);
    check("ko hurt2", hurt2, 0);
    check("ko round_over", round_over, 1);
    check("ko winner", winner, 1);
    check("ko hp1", hp1, 100);
    check("ko die1", die1, 0);
    hit1();
    attack2 = 1'b1;
    frame();
    frame();
    attack2 = 1'b0;
    frame();
    check("ko frozen hp1", hp1, 100);
    check("ko frozen hp2", hp2, 0);
    check("ko frozen winner", winner, 1);

    // Restart out of KO.
    do_restart();
    check_cleared("restart3");

    // Double KO.
    repeat (9) hit_both();
    check("dko pre hp1", hp1, 10);
    check("dko pre hp2", hp2, 10);
    check("dko pre round_over", round_over, 0);
    hit_both();
    check("dko hp1", hp1, 0);
    check("dko hp2", hp2, 0);
    check("dko die", {die1, die2}, 3);
    check("dko winner", winner, 3);
    check("dko round_over", round_over, 1);

    // Async reset mid-hurt, between Clk edges.
    do_restart();
    check_cleared("restart4");
    attack1 = 1'b1;
    frame();
    frame();
    check("pre reset hp2", hp2, 90);
    check("pre reset hurt2", hurt2, 1);
    game_state = 8'd0;
    attack1 = 1'b0;
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("async hp2", hp2, 100);
    check("async hurt2", hurt2, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    attack1 = 1'b1;
    frame();
    frame();
    attack1 = 1'b0;
    frame();
    check("post reset wait hp2", hp2, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
